// File: rtl/fir_output_decimator.sv
// Back end for the FIR accumulator: keeps one sample in DECIM, rounds and saturates
// it to N2 bits, and buffers the result in a small FIFO with a valid/ready output.
module fir_output_decimator #(
    parameter int N2    = 16,
    parameter int N3    = 32,
    parameter int DECIM = 4,
    parameter int SHIFT = 7,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic signed [N3-1:0]     in_data,
    input  logic                     in_valid,
    output logic signed [N2-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     sat_flag,
    output logic                     drop_flag,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [N3:0] RND     = (N3+1)'(1) << (SHIFT - 1);
    localparam logic signed [N3:0] SAT_MAX = (N3+1)'((2 ** (N2 - 1)) - 1);
    localparam logic signed [N3:0] SAT_MIN = -SAT_MAX - (N3+1)'(1);

    logic [PW-1:0]          phase;
    logic signed [N2-1:0]   mem [DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;

    logic signed [N3:0]     acc_ext;
    logic signed [N3:0]     acc_rnd;
    logic signed [N3:0]     acc_shr;
    logic signed [N2-1:0]   sample;
    logic                   sat;
    logic                   kept;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Extra headroom bit keeps the rounding add from wrapping at full scale.
    always_comb begin
        acc_ext = {in_data[N3-1], in_data};
        acc_rnd = acc_ext + RND;
        acc_shr = acc_rnd >>> SHIFT;
        sat     = 1'b0;
        sample  = acc_shr[N2-1:0];
        if (acc_shr > SAT_MAX) begin
            sat    = 1'b1;
            sample = SAT_MAX[N2-1:0];
        end else if (acc_shr < SAT_MIN) begin
            sat    = 1'b1;
            sample = SAT_MIN[N2-1:0];
        end
    end

    always_comb begin
        kept  = in_valid && (phase == '0);
        full  = (fill == (AW+1)'(DEPTH));
        empty = (fill == '0);
        pop   = !empty && out_ready;
        push  = kept && (!full || pop);
        drop  = kept && full && !pop;
    end

    assign out_valid = !empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PW'(DECIM - 1))
                phase <= '0;
            else
                phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            out_data <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
            // Head register: holds the last shown value while the FIFO is empty.
            if (empty && push)
                out_data <= sample;
            else if (pop) begin
                if (fill > (AW+1)'(1))
                    out_data <= mem[rd_ptr + AW'(1)];
                else if (push)
                    out_data <= sample;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (kept && sat)
                sat_flag <= 1'b1;
            else if (clr_flags)
                sat_flag <= 1'b0;
            if (drop)
                drop_flag <= 1'b1;
            else if (clr_flags)
                drop_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: a DECIM=1 and a DECIM=4 instance share
// the stimulus; each section checks the instance it targets.
module tb_fir_output_decimator;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic signed [31:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               clr_flags = 1'b0;

    logic [15:0] o1_data, o4_data;
    logic        o1_valid, o4_valid;
    logic [2:0]  o1_fill, o4_fill;
    logic        o1_sat, o4_sat, o1_drop, o4_drop;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fir_output_decimator #(.N2(16), .N3(32), .DECIM(1), .SHIFT(7), .DEPTH(4)) dut1 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .out_data(o1_data), .out_valid(o1_valid), .out_ready(out_ready),
        .fill(o1_fill), .sat_flag(o1_sat), .drop_flag(o1_drop), .clr_flags(clr_flags)
    );

    fir_output_decimator #(.N2(16), .N3(32), .DECIM(4), .SHIFT(7), .DEPTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .out_data(o4_data), .out_valid(o4_valid), .out_ready(out_ready),
        .fill(o4_fill), .sat_flag(o4_sat), .drop_flag(o4_drop), .clr_flags(clr_flags)
    );

    typedef struct {
        logic [31:0] din;
        logic        vld;
        logic        rdy;
        logic        clr;
        logic [15:0] e_data;
        logic        e_valid;
        logic [2:0]  e_fill;
        logic        e_sat;
        logic        e_drop;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] d, input logic v, input logic r, input logic c);
        in_data   = d;
        in_valid  = v;
        out_ready = r;
        clr_flags = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        RST       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd12800,     1'b1, 1'b1, 1'b0, 16'd100,    1'b1, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{32'd64,        1'b1, 1'b1, 1'b0, 16'd1,      1'b1, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFFFFC0,  1'b1, 1'b1, 1'b0, 16'd0,      1'b1, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{32'hFFFFFFBF,  1'b1, 1'b1, 1'b0, 16'hFFFF,   1'b1, 3'd1, 1'b0, 1'b0};
        vecs[4]  = '{32'd0,         1'b0, 1'b1, 1'b0, 16'hFFFF,   1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{32'h7FFFFFFF,  1'b1, 1'b1, 1'b0, 16'h7FFF,   1'b1, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{32'h80000000,  1'b1, 1'b1, 1'b0, 16'h8000,   1'b1, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{32'd0,         1'b0, 1'b1, 1'b1, 16'h8000,   1'b0, 3'd0, 1'b0, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF,  1'b1, 1'b1, 1'b1, 16'h7FFF,   1'b1, 3'd1, 1'b1, 1'b0};
        vecs[9]  = '{32'd640,       1'b1, 1'b1, 1'b0, 16'd5,      1'b1, 3'd1, 1'b1, 1'b0};
        vecs[10] = '{32'd0,         1'b0, 1'b0, 1'b0, 16'd5,      1'b1, 3'd1, 1'b1, 1'b0};

        do_reset();
        chk("rst_data",  32'(o1_data), 32'd0);
        chk("rst_valid", 32'(o1_valid), 32'd0);
        chk("rst_fill",  32'(o1_fill), 32'd0);
        chk("rst_sat",   32'(o1_sat), 32'd0);
        chk("rst_drop",  32'(o1_drop), 32'd0);

        // DECIM=1 rounding, saturation and flag clear
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].din, vecs[i].vld, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d_data", i),  32'(o1_data),  32'(vecs[i].e_data));
            chk($sformatf("v%0d_valid", i), 32'(o1_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_fill", i),  32'(o1_fill),  32'(vecs[i].e_fill));
            chk($sformatf("v%0d_sat", i),   32'(o1_sat),   32'(vecs[i].e_sat));
            chk($sformatf("v%0d_drop", i),  32'(o1_drop),  32'(vecs[i].e_drop));
        end

        // Overflow: six pushes into a four-deep FIFO with the sink stalled
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            apply(32'(128 * k), 1'b1, 1'b0, 1'b0);
            if (k == 4) begin
                chk("ovf_fill4", 32'(o1_fill), 32'd4);
                chk("ovf_nodrop", 32'(o1_drop), 32'd0);
            end
        end
        chk("ovf_fill", 32'(o1_fill), 32'd4);
        chk("ovf_drop", 32'(o1_drop), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_pop%0d", k), 32'(o1_data), 32'(k));
            apply(32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("ovf_empty", 32'(o1_valid), 32'd0);
        chk("ovf_fill0", 32'(o1_fill), 32'd0);
        chk("ovf_hold",  32'(o1_data), 32'd4);
        apply(32'd0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(o1_drop), 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 1; k <= 4; k++)
            apply(32'(128 * 10 * k), 1'b1, 1'b0, 1'b0);
        chk("fpp_fill_pre", 32'(o1_fill), 32'd4);
        apply(32'(128 * 50), 1'b1, 1'b1, 1'b0);
        chk("fpp_fill", 32'(o1_fill), 32'd4);
        chk("fpp_drop", 32'(o1_drop), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fpp_pop%0d", k), 32'(o1_data), 32'(10 * k));
            apply(32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("fpp_empty", 32'(o1_valid), 32'd0);

        // DECIM=4 with gaps in in_valid
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(32'(128 * k), 1'b1, 1'b0, 1'b0);
            if (k == 0) begin
                chk("d4_lat_valid", 32'(o4_valid), 32'd1);
                chk("d4_lat_data",  32'(o4_data), 32'd0);
            end
            if (k == 1 || k == 3) begin
                apply(32'(128 * 99), 1'b0, 1'b0, 1'b0);
                apply(32'(128 * 99), 1'b0, 1'b0, 1'b0);
            end
        end
        chk("d4_fill", 32'(o4_fill), 32'd2);
        chk("d4_head", 32'(o4_data), 32'd0);
        chk("d4_sat",  32'(o4_sat),  32'd0);
        apply(32'd0, 1'b0, 1'b1, 1'b0);
        chk("d4_second", 32'(o4_data), 32'd4);
        chk("d4_fill1",  32'(o4_fill), 32'd1);
        apply(32'd0, 1'b0, 1'b1, 1'b0);
        chk("d4_empty", 32'(o4_valid), 32'd0);

        // Asynchronous reset with three entries buffered
        do_reset();
        apply(32'd128, 1'b1, 1'b0, 1'b0);
        apply(32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        apply(32'd256, 1'b1, 1'b0, 1'b0);
        chk("mr_fill_pre", 32'(o1_fill), 32'd3);
        chk("mr_sat_pre",  32'(o1_sat), 32'd1);
        in_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        chk("mr_valid", 32'(o1_valid), 32'd0);
        chk("mr_fill",  32'(o1_fill), 32'd0);
        chk("mr_sat",   32'(o1_sat), 32'd0);
        chk("mr_drop",  32'(o1_drop), 32'd0);
        chk("mr_data",  32'(o1_data), 32'd0);
        chk("mr_fill4", 32'(o4_fill), 32'd0);
        #1;
        RST = 1'b1;
        apply(32'(128 * 7), 1'b1, 1'b0, 1'b0);
        chk("mr_first1", 32'(o1_data), 32'd7);
        chk("mr_fill1",  32'(o1_fill), 32'd1);
        chk("mr_first4", 32'(o4_data), 32'd7);
        chk("mr_fill4b", 32'(o4_fill), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
Consumer-side back end for the FIR filter's accumulated output. It takes each 32-bit filter result, keeps one sample in DECIM, and rescales it to a 16-bit sample with rounding and saturation. Kept samples are buffered in a small FIFO and leave through a valid/ready handshake toward the downstream sink. Status flags report saturation and dropped samples.

Parameters:
N2, 16, output sample width (bits)
N3, 32, input accumulator width (bits)
DECIM, 4, decimation factor (>=1); DECIM=1 keeps every sample
SHIFT, 7, arithmetic right-shift applied to the accumulator (8 taps x coef 16 = gain 128), >=1
DEPTH, 4, FIFO depth (entries, power of two)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
in_data  input  N3  signed filter accumulator result
in_valid  input  1  in_data valid this cycle (integration drives it from the filter Enable delayed one cycle)
out_data  output  N2  signed head-of-FIFO sample
out_valid  output  1  FIFO not empty
out_ready  input  1  sink accepts out_data this cycle
fill  output  clog2(DEPTH)+1  current FIFO occupancy
sat_flag  output  1  sticky: a kept sample was saturated
drop_flag  output  1  sticky: a kept sample was lost on full FIFO
clr_flags  input  1  synchronous clear of sat_flag and drop_flag

Behaviour:
- One clock domain. Reset is asynchronous and active-low on RST; clock port is CLK.
- Reset values: out_data=0, out_valid=0, fill=0, sat_flag=0, drop_flag=0, decimation phase=0, FIFO pointers=0. Reset mid-operation discards all buffered samples immediately.
- Decimation phase counter runs 0..DECIM-1 and advances only on in_valid, wrapping to 0.
- A sample is "kept" when in_valid=1 and phase=0. The first valid sample after reset is kept. Non-kept samples are ignored entirely; they set no flags.
- Scaling is combinational on the kept sample, in N3+1 bits to avoid overflow:
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - Saturate r to [-2^(N2-1), 2^(N2-1)-1].
  - If clipping occurs, set sat_flag on the next edge.
- Push: the kept, scaled sample is written to FIFO on the same edge. It is visible on out_data with out_valid=1 the following cycle. Latency in_valid to out_valid = 1 cycle when the FIFO was empty.
- Pop: occurs on an edge where out_valid=1 and out_ready=1. The next entry, if any, appears on out_data after that edge. out_ready while empty has no effect.
- Full FIFO (fill=DEPTH):
  - Push with a simultaneous pop: both succeed; fill stays DEPTH.
  - Push without a pop: the sample is discarded, drop_flag is set, and FIFO contents are unchanged. A saturation on a dropped sample still sets sat_flag.
- Push and pop in the same cycle on a non-full, non-empty FIFO: fill unchanged.
- Pointers wrap modulo DEPTH. out_data holds its value when there is no pop.
- out_data is undefined-free: it shows the last head value (0 after reset) while empty.
- Flags are sticky until clr_flags=1 or reset. If clr_flags coincides with a new set event, the set wins.
- fill is registered and equals pushes minus pops since reset.

Test Plan:
- DECIM=1: in_data=12800, 64, -64, -65 on consecutive valid cycles, out_ready=1 -> out_data 100, 1, 0, -1 each one cycle after input; sat_flag=0.
- Saturation: in_data=32'h7FFFFFFF then 32'h80000000 -> out_data 32767 then -32768; sat_flag=1; clr_flags pulse -> sat_flag=0 next cycle.
- DECIM=4: in_data=128*k for k=0..7, one per cycle, in_valid held high -> exactly two outputs, 0 and 4; gaps in in_valid do not advance the phase.
- Overflow: out_ready=0, DECIM=1, six valid samples 128*1..128*6 -> fill=4, drop_flag=1; popping yields 1, 2, 3, 4 only.
- Full with simultaneous push and pop: fill=4, out_ready=1 and a kept sample in the same cycle -> fill stays 4, drop_flag stays 0, order preserved.
- Reset mid-stream: assert RST low asynchronously with fill=3 -> out_valid=0, fill=0, flags=0 immediately. The first valid sample after release is kept.
